// File: rtl/pkt_gen_param.sv
// Parametrised AXI-stream packet generator emitting {pkt_seq, beat_idx} lane patterns.
// Define PKGEN_STATS_EN to add saturating beat/stall statistics outputs.
module pkt_gen_param #(
    parameter int DATA_W  = 512,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int CNT_W   = 32,
    localparam int TAIL_W = $clog2(KEEP_W) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic [CNT_W-1:0]  io_idle_cycle,
    input  logic [15:0]       io_pkt_beats,
    input  logic [TAIL_W-1:0] io_tail_bytes,
    input  logic [CNT_W-1:0]  io_pkt_num,
    input  logic              io_data_out_ready,
    output logic              io_data_out_valid,
    output logic [DATA_W-1:0] io_data_out_bits_data,
    output logic [KEEP_W-1:0] io_data_out_bits_keep,
    output logic              io_data_out_bits_last,
    output logic              io_busy,
    output logic              io_done,
`ifdef PKGEN_STATS_EN
    output logic [CNT_W-1:0]  io_stat_beats,
    output logic [CNT_W-1:0]  io_stat_stalls,
`endif
    output logic [CNT_W-1:0]  io_pkt_cnt
);

    localparam int LANES = DATA_W / 32;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  idle_q, idle_d;
    logic [15:0]       beats_q, beats_d;
    logic [KEEP_W-1:0] tail_keep_q, tail_keep_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [15:0]       beat_q, beat_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  gap_q, gap_d;

    logic [KEEP_W-1:0] tail_keep_cfg;
    logic [CNT_W:0]    pkt_cnt_inc;
    logic              fire;
    logic              is_last;
    logic              run_start;

    // Tail byte count of 0 or beyond the bus width means a full last beat.
    always_comb begin
        tail_keep_cfg = '1;
        if (io_tail_bytes != '0 && io_tail_bytes <= TAIL_W'(KEEP_W)) begin
            for (int i = 0; i < KEEP_W; i++) begin
                tail_keep_cfg[i] = (i < int'(io_tail_bytes));
            end
        end
    end

    assign fire        = (state_q == S_SEND) && io_data_out_ready;
    assign is_last     = (beat_q == beats_q - 16'd1);
    assign run_start   = (state_q == S_IDLE) && io_start;
    assign pkt_cnt_inc = {1'b0, pkt_cnt_q} + {1'b0, CNT_ONE};

    always_comb begin
        state_d     = state_q;
        idle_d      = idle_q;
        beats_d     = beats_q;
        tail_keep_d = tail_keep_q;
        num_d       = num_q;
        beat_d      = beat_q;
        pkt_cnt_d   = pkt_cnt_q;
        gap_d       = gap_q;
        case (state_q)
            S_IDLE: begin
                if (io_start) begin
                    state_d     = S_SEND;
                    idle_d      = io_idle_cycle;
                    beats_d     = (io_pkt_beats == 16'd0) ? 16'd1 : io_pkt_beats;
                    tail_keep_d = tail_keep_cfg;
                    num_d       = io_pkt_num;
                    beat_d      = '0;
                    pkt_cnt_d   = '0;
                end
            end
            S_SEND: begin
                if (fire) begin
                    if (is_last) begin
                        beat_d = '0;
                        if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + CNT_ONE;
                        if (num_q != '0 && pkt_cnt_inc == {1'b0, num_q}) begin
                            state_d = S_DONE;
                        end else if (!io_start) begin
                            state_d = S_IDLE;
                        end else if (idle_q == '0) begin
                            state_d = S_SEND;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = idle_q - CNT_ONE;
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = io_start ? S_SEND : S_IDLE;
                end else begin
                    gap_d = gap_q - CNT_ONE;
                end
            end
            S_DONE: begin
                if (!io_start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idle_q      <= '0;
            beats_q     <= 16'd1;
            tail_keep_q <= '1;
            num_q       <= '0;
            beat_q      <= '0;
            pkt_cnt_q   <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            beats_q     <= beats_d;
            tail_keep_q <= tail_keep_d;
            num_q       <= num_d;
            beat_q      <= beat_d;
            pkt_cnt_q   <= pkt_cnt_d;
            gap_q       <= gap_d;
        end
    end

    // NOTE: outputs are decoded from registered state, so an async reset clears them at once
    // and the beat stays stable for as long as the sink stalls.
    always_comb begin
        io_data_out_valid     = (state_q == S_SEND);
        io_data_out_bits_last = io_data_out_valid && is_last;
        io_data_out_bits_keep = '0;
        io_data_out_bits_data = '0;
        if (io_data_out_valid) begin
            io_data_out_bits_keep = is_last ? tail_keep_q : '1;
            for (int l = 0; l < LANES; l++) begin
                io_data_out_bits_data[l*32 +: 32] = {pkt_cnt_q[15:0], beat_q};
            end
        end
    end

    assign io_busy    = (state_q == S_SEND) || (state_q == S_GAP);
    assign io_done    = (state_q == S_DONE);
    assign io_pkt_cnt = pkt_cnt_q;

`ifdef PKGEN_STATS_EN
    logic [CNT_W-1:0] stat_beats_q;
    logic [CNT_W-1:0] stat_stalls_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_beats_q  <= '0;
            stat_stalls_q <= '0;
        end else if (run_start) begin
            stat_beats_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (fire && stat_beats_q != '1) stat_beats_q <= stat_beats_q + CNT_ONE;
            if (io_data_out_valid && !io_data_out_ready && stat_stalls_q != '1)
                stat_stalls_q <= stat_stalls_q + CNT_ONE;
        end
    end

    assign io_stat_beats  = stat_beats_q;
    assign io_stat_stalls = stat_stalls_q;
`else
    logic unused_run_start;
    assign unused_run_start = run_start;
`endif

endmodule

// File: tb/tb_pkt_gen_param.sv
// Directed self-checking bench for pkt_gen_param built at DATA_W=64 (two payload lanes).
module tb_pkt_gen_param;

    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;
    localparam int CNT_W  = 32;
    localparam int TAIL_W = $clog2(KEEP_W) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  idle;
    logic [15:0]       beats;
    logic [TAIL_W-1:0] tail;
    logic [CNT_W-1:0]  num;
    logic              ready;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pkt_cnt;
`ifdef PKGEN_STATS_EN
    logic [CNT_W-1:0]  stat_beats;
    logic [CNT_W-1:0]  stat_stalls;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pkt_gen_param #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_start              (start),
        .io_idle_cycle         (idle),
        .io_pkt_beats          (beats),
        .io_tail_bytes         (tail),
        .io_pkt_num            (num),
        .io_data_out_ready     (ready),
        .io_data_out_valid     (valid),
        .io_data_out_bits_data (data),
        .io_data_out_bits_keep (keep),
        .io_data_out_bits_last (last),
        .io_busy               (busy),
        .io_done               (done),
`ifdef PKGEN_STATS_EN
        .io_stat_beats         (stat_beats),
        .io_stat_stalls        (stat_stalls),
`endif
        .io_pkt_cnt            (pkt_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] lanes(input int seq, input int beat);
        logic [31:0] w;
        w = {seq[15:0], beat[15:0]};
        return {w, w};
    endfunction

    initial begin
        int gap_cycles;
        int nbeats;
        int stalls;
        int cyc;
        int saw_valid;
        logic busy_ok;
        logic have_prev;
        logic [DATA_W-1:0] prev_data;
        logic [KEEP_W-1:0] prev_keep;
        logic              prev_last;

        reset = 1'b1; start = 1'b0; idle = '0; beats = 16'd1; tail = '0; num = '0; ready = 1'b1;
        #12;
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_keep", keep, 0);
        check("rst_data", data, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        reset = 1'b0;
        tick();

        // T1: 3 back-to-back packets of 4 full beats
        beats = 16'd4; tail = '0; idle = '0; num = 32'd3; ready = 1'b1; start = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            check("t1_valid", valid, 1);
            check("t1_last", last, (i % 4) == 3);
            check("t1_keep", keep, 8'hFF);
            check("t1_data", data, lanes(i / 4, i % 4));
            tick();
        end
        check("t1_done", done, 1);
        check("t1_valid_after", valid, 0);
        check("t1_pkt_cnt", pkt_cnt, 3);
        check("t1_busy_after", busy, 0);
        start = 1'b0;
        tick();
        check("t1_rearm_idle", done, 0);

        // T2: 2-beat packets, 5-byte tail, 10-cycle gap
        beats = 16'd2; tail = 4'd5; idle = 32'd10; num = 32'd2; start = 1'b1;
        tick();
        check("t2_p0b0_keep", keep, 8'hFF);
        check("t2_p0b0_last", last, 0);
        tick();
        check("t2_p0b1_keep", keep, 8'h1F);
        check("t2_p0b1_last", last, 1);
        tick();
        gap_cycles = 0;
        busy_ok = 1'b1;
        while (valid !== 1'b1 && gap_cycles < 50) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            gap_cycles++;
            tick();
        end
        check("t2_gap_len", gap_cycles, 10);
        check("t2_gap_busy", busy_ok, 1);
        check("t2_p1b0_data", data, lanes(1, 0));
        tick();
        check("t2_p1b1_lane0", data[31:0], 32'h00010001);
        check("t2_p1b1_keep", keep, 8'h1F);
        tick();
        check("t2_done", done, 1);
        start = 1'b0;
        tick();

        // T3: random backpressure, 5 packets of 8 beats
        beats = 16'd8; tail = '0; idle = '0; num = 32'd5; start = 1'b1;
        ready = 1'($urandom_range(0, 1));
        tick();
        nbeats = 0; stalls = 0; cyc = 0; have_prev = 1'b0;
        prev_data = '0; prev_keep = '0; prev_last = 1'b0;
        while (done !== 1'b1 && cyc < 1000) begin
            if (have_prev) begin
                check("t3_hold_data", data, prev_data);
                check("t3_hold_keep", keep, prev_keep);
                check("t3_hold_last", last, prev_last);
            end
            have_prev = 1'b0;
            if (valid === 1'b1) begin
                if (ready) begin
                    check("t3_data", data, lanes(nbeats / 8, nbeats % 8));
                    check("t3_last", last, (nbeats % 8) == 7);
                    nbeats++;
                end else begin
                    stalls++;
                    have_prev = 1'b1;
                    prev_data = data; prev_keep = keep; prev_last = last;
                end
            end
            tick();
            cyc++;
            ready = 1'($urandom_range(0, 1));
        end
        ready = 1'b1;
        check("t3_beats", nbeats, 40);
        check("t3_done", done, 1);
        check("t3_pkt_cnt", pkt_cnt, 5);
`ifdef PKGEN_STATS_EN
        check("t3_stat_beats", stat_beats, 40);
        check("t3_stat_stalls", stat_stalls, stalls);
`endif
        start = 1'b0;
        tick();

        // T4: unbounded run, start dropped during beat 3 of 6
        beats = 16'd6; num = '0; idle = '0; start = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("t4_valid", valid, 1);
            check("t4_data", data, lanes(0, i));
            check("t4_last", last, i == 5);
            if (i == 2) start = 1'b0;
            tick();
        end
        check("t4_busy", busy, 0);
        check("t4_valid_after", valid, 0);
        check("t4_pkt_cnt", pkt_cnt, 1);
        saw_valid = 0;
        for (int i = 0; i < 5; i++) begin
            if (valid !== 1'b0) saw_valid++;
            tick();
        end
        check("t4_no_more_valid", saw_valid, 0);

        // T5: async reset in the middle of the second packet
        beats = 16'd4; num = '0; idle = '0; start = 1'b1;
        tick();
        repeat (5) tick();
        check("t5_pre_cnt", pkt_cnt, 1);
        check("t5_pre_data", data, lanes(1, 1));
        #2 reset = 1'b1;
        #1;
        check("t5_rst_valid", valid, 0);
        check("t5_rst_pkt_cnt", pkt_cnt, 0);
        check("t5_rst_data", data, 0);
        check("t5_rst_busy", busy, 0);
        #1 reset = 1'b0;
        tick();
        check("t5_restart_valid", valid, 1);
        check("t5_restart_data", data, lanes(0, 0));
        start = 1'b0;
        repeat (6) tick();
        check("t5_idle", busy, 0);

        // T6: beats=0 means single-beat packets, each with last and tail keep
        beats = 16'd0; tail = 4'd3; num = 32'd3; idle = '0; start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t6_valid", valid, 1);
            check("t6_last", last, 1);
            check("t6_keep", keep, 8'h07);
            check("t6_data", data, lanes(i, 0));
            tick();
        end
        check("t6_done", done, 1);
        check("t6_pkt_cnt", pkt_cnt, 3);
        start = 1'b0;
        tick();
        check("t6_idle", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
